// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between vga_sync/renderer, the VRAM port arbiter and the frame-buffer RAM.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface vram_port_arbiter_if;
  logic        rdn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [11:0] pix_out;
  logic        wr_req;
  logic        wr_ready;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_drop;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  modport slave (
    input  rdn, row_addr, col_addr, wr_req, wr_row, wr_col, wr_data,
           clr_req, clr_color, ram_rdata,
    output pix_out, wr_ready, clr_busy, clr_done, wr_drop,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output rdn, row_addr, col_addr, wr_req, wr_row, wr_col, wr_data,
           clr_req, clr_color, ram_rdata,
    input  pix_out, wr_ready, clr_busy, clr_done, wr_drop,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares a single-port async-read pixel RAM between scan-out reads (absolute priority),
// a frame-clear sweep and a small renderer write FIFO drained in blanking cycles.
module vram_port_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480
) (
  input  logic                 vga_clk,
  input  logic                 clrn,
  vram_port_arbiter_if.slave   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q;
  logic [8:0]  clr_row_q;
  logic [9:0]  clr_col_q;
  logic [11:0] clr_color_q;
  logic        clr_busy_q;
  logic        clr_done_q;
  logic        wr_drop_q;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [18:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [11:0]   fifo_data_mem [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop;
  logic clr_col_last, clr_row_last;

  // Depth is a power of two, so the count MSB alone marks a full FIFO.
  assign fifo_full    = count_q[PW];
  assign fifo_empty   = (count_q == '0);
  assign push         = bus.wr_req & ~fifo_full;
  assign pop          = bus.rdn & (state_q == IDLE) & ~fifo_empty;
  assign clr_col_last = (clr_col_q == 10'(H_PIX - 1));
  assign clr_row_last = (clr_row_q == 9'(V_PIX - 1));

  assign bus.wr_ready = ~fifo_full;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.wr_drop  = wr_drop_q;

  always_comb begin
    bus.ram_addr  = {bus.row_addr, bus.col_addr};
    bus.ram_we    = 1'b0;
    bus.ram_wdata = 12'h000;
    bus.pix_out   = 12'h000;
    if (!bus.rdn) begin
      bus.pix_out = bus.ram_rdata;
    end else if (state_q == CLEAR) begin
      bus.ram_addr  = {clr_row_q, clr_col_q};
      bus.ram_we    = 1'b1;
      bus.ram_wdata = clr_color_q;
    end else if (!fifo_empty) begin
      bus.ram_addr  = fifo_addr_mem[rd_ptr_q];
      bus.ram_we    = 1'b1;
      bus.ram_wdata = fifo_data_mem[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= {bus.wr_row, bus.wr_col};
      fifo_data_mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      clr_row_q   <= '0;
      clr_col_q   <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      if (bus.wr_req && fifo_full) wr_drop_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q     <= CLEAR;
            clr_busy_q  <= 1'b1;
            clr_color_q <= bus.clr_color;
            clr_row_q   <= '0;
            clr_col_q   <= '0;
          end
        end
        CLEAR: begin
          // Scan-out cycles hold the sweep where it is.
          if (bus.rdn) begin
            if (clr_col_last) begin
              clr_col_q <= '0;
              if (clr_row_last) begin
                clr_row_q  <= '0;
                state_q    <= IDLE;
                clr_busy_q <= 1'b0;
                clr_done_q <= 1'b1;
              end else begin
                clr_row_q <= clr_row_q + 1'b1;
              end
            end else begin
              clr_col_q <= clr_col_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomized directed bench for vram_port_arbiter on a reduced 16x8 frame; a queue/index
// reference model predicts every RAM-port cycle and the status outputs.
module tb_vram_port_arbiter;
  localparam int DEPTH = 4;
  localparam int HP    = 16;
  localparam int VP    = 8;

  logic vga_clk = 1'b0;
  logic clrn    = 1'b0;

  vram_port_arbiter_if bus();

  vram_port_arbiter #(.FIFO_DEPTH(DEPTH), .H_PIX(HP), .V_PIX(VP)) dut (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .bus     (bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [18:0] a;
    logic [11:0] d;
  } wr_t;

  wr_t         mq[$];
  bit          m_clear, m_done, m_drop;
  int          m_idx;
  logic [11:0] m_color;
  logic [11:0] tb_ram [int];
  int          n_cmp = 0, n_bad = 0;
  int          n_wr = 0, n_done = 0;
  logic [18:0] last_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_clear = 0; m_done = 0; m_drop = 0; m_idx = 0; m_color = '0;
  endtask

  task automatic quiet();
    bus.rdn = 1'b1; bus.row_addr = '0; bus.col_addr = '0;
    bus.wr_req = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0; bus.clr_color = '0;
  endtask

  task automatic rand_write(input bit en);
    bus.wr_req  = en;
    bus.wr_row  = 9'($urandom_range(0, VP - 1));
    bus.wr_col  = 10'($urandom_range(0, HP - 1));
    bus.wr_data = 12'($urandom);
  endtask

  // One clock: called just after a falling edge with inputs already set.
  task automatic step();
    logic [18:0] ea;
    logic        ewe;
    logic [11:0] ewd, epix;
    bit          was_clear;
    int          qs;
    if (!bus.rdn) begin
      if (tb_ram.exists(int'({bus.row_addr, bus.col_addr})))
        bus.ram_rdata = tb_ram[int'({bus.row_addr, bus.col_addr})];
      else
        bus.ram_rdata = 12'h000;
    end else begin
      bus.ram_rdata = 12'($urandom);
    end
    #1;
    ewe = 1'b0; ea = {bus.row_addr, bus.col_addr}; ewd = '0; epix = '0;
    if (!bus.rdn) begin
      epix = bus.ram_rdata;
    end else if (m_clear) begin
      ewe = 1'b1; ea = {9'(m_idx / HP), 10'(m_idx % HP)}; ewd = m_color;
    end else if (mq.size() > 0) begin
      ewe = 1'b1; ea = mq[0].a; ewd = mq[0].d;
    end
    chk("ram_we", 32'(bus.ram_we), 32'(ewe));
    chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
    if (ewe) chk("ram_wdata", 32'(bus.ram_wdata), 32'(ewd));
    chk("pix_out", 32'(bus.pix_out), 32'(epix));
    chk("wr_ready", 32'(bus.wr_ready), 32'(mq.size() < DEPTH));
    chk("clr_busy", 32'(bus.clr_busy), 32'(m_clear));
    chk("clr_done", 32'(bus.clr_done), 32'(m_done));
    chk("wr_drop", 32'(bus.wr_drop), 32'(m_drop));
    if (bus.ram_we === 1'b1) begin
      tb_ram[int'(bus.ram_addr)] = bus.ram_wdata;
      n_wr++;
      last_wr = bus.ram_addr;
    end
    if (bus.clr_done === 1'b1) n_done++;
    @(posedge vga_clk);
    was_clear = m_clear;
    qs = mq.size();
    m_done = 0;
    if (bus.rdn) begin
      if (was_clear) begin
        m_idx++;
        if (m_idx == HP * VP) begin
          m_clear = 0;
          m_done  = 1;
        end
      end else if (qs > 0) begin
        void'(mq.pop_front());
      end
    end
    if (bus.wr_req) begin
      if (qs < DEPTH) mq.push_back('{a: {bus.wr_row, bus.wr_col}, d: bus.wr_data});
      else m_drop = 1;
    end
    if (!was_clear && bus.clr_req) begin
      m_clear = 1; m_idx = 0; m_color = bus.clr_color;
    end
    @(negedge vga_clk);
  endtask

  initial begin
    int base_wr, base_done, guard;
    quiet();
    bus.ram_rdata = '0;
    model_reset();

    // T1: reset held with a write request pending
    clrn = 1'b0;
    bus.wr_req = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
    chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("rst_clr_done", 32'(bus.clr_done), 32'd0);
    @(negedge vga_clk);
    quiet();
    clrn = 1'b1;
    step();

    // T2: scan-out read wins while three writes queue up, then they drain in order
    tb_ram[int'(19'h01407)] = 12'hABC;
    bus.rdn = 1'b0; bus.row_addr = 9'd5; bus.col_addr = 10'd7;
    for (int i = 0; i < 3; i++) begin
      rand_write(1'b1);
      step();
    end
    bus.wr_req = 1'b0;
    #1;
    chk("t2_addr", 32'(bus.ram_addr), 32'h01407);
    chk("t2_pix", 32'(bus.pix_out), 32'hABC);
    chk("t2_we", 32'(bus.ram_we), 32'd0);
    @(negedge vga_clk);
    bus.rdn = 1'b1;
    base_wr = n_wr;
    repeat (4) step();
    chk("t2_drain_count", 32'(n_wr - base_wr), 32'd3);

    // T3: overflow while reads hold the port
    bus.rdn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.col_addr = 10'($urandom_range(0, HP - 1));
      rand_write(1'b1);
      step();
    end
    bus.wr_req = 1'b0;
    bus.rdn = 1'b1;
    base_wr = n_wr;
    repeat (6) step();
    chk("t3_drain_count", 32'(n_wr - base_wr), 32'd4);
    chk("t3_wr_drop", 32'(bus.wr_drop), 32'd1);

    // T4: full clear with no scan-out
    base_wr = n_wr;
    base_done = n_done;
    bus.clr_req = 1'b1; bus.clr_color = 12'h0F0;
    step();
    bus.clr_req = 1'b0;
    guard = 0;
    while (m_clear && guard < 4 * HP * VP) begin
      step();
      guard++;
    end
    chk("t4_timeout", 32'(guard < 4 * HP * VP), 32'd1);
    chk("t4_write_count", 32'(n_wr - base_wr), 32'(HP * VP));
    chk("t4_last_addr", 32'(last_wr), 32'({9'(VP - 1), 10'(HP - 1)}));
    step();
    chk("t4_done_count", 32'(n_done - base_done), 32'd1);
    for (int r = 0; r < VP; r++) begin
      for (int c = 0; c < HP; c++) begin
        bus.rdn = 1'b0; bus.row_addr = 9'(r); bus.col_addr = 10'(c);
        step();
        #1;
        chk("t4_readback", 32'(bus.pix_out), 32'h0F0);
        @(negedge vga_clk);
      end
    end

    // T5: clear interleaved with a scaled scan pattern and random renderer writes
    base_done = n_done;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      int h, ln;
      h  = cyc % 24;
      ln = (cyc / 24) % 12;
      bus.rdn      = !(h < 16 && ln < 8);
      bus.row_addr = 9'(ln % VP);
      bus.col_addr = 10'(h % HP);
      bus.clr_req  = (cyc == 0) || (m_clear && $urandom_range(0, 40) == 0);
      bus.clr_color = 12'($urandom);
      rand_write($urandom_range(0, 9) < 2);
      step();
    end
    chk("t5_done_count", 32'(n_done - base_done), 32'd1);
    quiet();
    repeat (6) step();

    // T6: asynchronous reset part-way through a clear
    base_done = n_done;
    bus.clr_req = 1'b1; bus.clr_color = 12'($urandom);
    step();
    bus.clr_req = 1'b0;
    guard = 0;
    while (m_idx < 4 * HP && guard < 4 * HP * VP) begin
      step();
      guard++;
    end
    chk("t6_busy_before", 32'(bus.clr_busy), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("t6_busy_at_reset", 32'(bus.clr_busy), 32'd0);
    chk("t6_we_at_reset", 32'(bus.ram_we), 32'd0);
    model_reset();
    @(negedge vga_clk);
    clrn = 1'b1;
    repeat (5) step();
    chk("t6_no_done", 32'(n_done - base_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
